fp_compose80: RTL and testbench

FP_COMPOSE80 -- requirements
Module: fp_compose80

---
 rtl/fp_compose80.sv | 265 ++++++++++++++++++++++++++
 tb/tb_fp_compose80.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_compose80.sv
// ============================================================================
// Module   : fp_compose80
// Purpose  : Normalises, rounds and packs an extended-precision intermediate
//            (sign, 17-bit signed biased exponent, 68-bit mantissa with
//            guard/round/sticky) into an 80-bit x87-style result with flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_compose80 (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sgn,
  input  logic [16:0] in_exp,
  input  logic [67:0] in_man,
  input  logic        in_inf,
  input  logic        in_nan,
  input  logic        in_snan,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] o,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        invalid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LSH  = 3'd1,
    S_RSH  = 3'd2,
    S_RND  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Exponent is carried at 18 bits so the rounding increment of the largest
  // 17-bit input exponent cannot wrap.
  localparam logic signed [17:0] EXP_ONE   = 18'sd1;
  localparam logic signed [17:0] EXP_EIGHT = 18'sd8;
  localparam logic signed [17:0] EXP_RSH8  = -18'sd7;
  localparam logic signed [17:0] EXP_FLUSH = -18'sd70;
  localparam logic signed [17:0] EXP_OVF   = 18'sd32767;
  localparam logic [14:0]        ENC_INF   = 15'h7FFF;
  localparam logic [14:0]        ENC_MAXF  = 15'h7FFE;
  localparam logic [63:0]        SIG_QNAN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0]        SIG_MAXF  = 64'hFFFF_FFFF_FFFF_FFFF;

  state_t             r_state, w_state_nxt;
  logic               r_sgn, w_sgn_nxt;
  logic signed [17:0] r_exp, w_exp_nxt;
  logic [67:0]        r_man, w_man_nxt;
  logic [2:0]         r_rm, w_rm_nxt;
  logic [79:0]        r_o, w_o_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_unf, w_unf_nxt;
  logic               r_inx, w_inx_nxt;
  logic               r_inv, w_inv_nxt;

  logic signed [17:0] w_in_exp;
  assign w_in_exp = {in_exp[16], in_exp};

  // Rounding datapath: evaluated from the registered operand, used in RND.
  logic               w_lsb, w_g, w_r, w_s, w_inc, w_to_inf;
  logic [65:0]        w_sum;
  logic [64:0]        w_rman;
  logic signed [17:0] w_rexp;
  logic [79:0]        w_rnd_o;
  logic               w_rnd_ovf, w_rnd_unf, w_rnd_inx;

  // Round the 65-bit significand, renormalise a carry-out, then encode or saturate.
  always_comb begin
    w_lsb = r_man[3];
    w_g   = r_man[2];
    w_r   = r_man[1];
    w_s   = r_man[0];
    w_inc = 1'b0;
    case (r_rm)
      3'd1:    w_inc = 1'b0;
      3'd2:    w_inc = r_sgn & (w_g | w_r | w_s);
      3'd3:    w_inc = ~r_sgn & (w_g | w_r | w_s);
      3'd4:    w_inc = w_g;
      default: w_inc = w_g & (w_r | w_s | w_lsb);
    endcase

    w_sum = {1'b0, r_man[67:3]} + {65'd0, w_inc};
    if (w_sum[65]) begin
      w_rman = w_sum[65:1];
      w_rexp = r_exp + EXP_ONE;
    end else begin
      w_rman = w_sum[64:0];
      w_rexp = r_exp;
    end

    // Overflow saturates toward infinity only when the mode rounds away from zero.
    w_to_inf = 1'b1;
    case (r_rm)
      3'd1:    w_to_inf = 1'b0;
      3'd2:    w_to_inf = r_sgn;
      3'd3:    w_to_inf = ~r_sgn;
      default: w_to_inf = 1'b1;
    endcase

    w_rnd_o   = '0;
    w_rnd_ovf = 1'b0;
    w_rnd_unf = 1'b0;
    w_rnd_inx = w_g | w_r | w_s;
    if (w_rexp >= EXP_OVF) begin
      w_rnd_ovf = 1'b1;
      w_rnd_inx = 1'b1;
      if (w_to_inf) begin
        w_rnd_o = {r_sgn, ENC_INF, 64'd0};
      end else begin
        w_rnd_o = {r_sgn, ENC_MAXF, SIG_MAXF};
      end
    end else begin
      // A subnormal (exp 1) that rounds into the hidden bit encodes exp 1 directly.
      w_rnd_o   = {r_sgn, (w_rman[64] ? w_rexp[14:0] : 15'd0), w_rman[63:0]};
      w_rnd_unf = ~r_man[67] & (w_g | w_r | w_s);
    end
  end

  // Next-state, normalisation shifts and result capture on entry to DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_sgn_nxt   = r_sgn;
    w_exp_nxt   = r_exp;
    w_man_nxt   = r_man;
    w_rm_nxt    = r_rm;
    w_o_nxt     = r_o;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_inx_nxt   = r_inx;
    w_inv_nxt   = r_inv;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sgn_nxt = in_sgn;
          w_exp_nxt = w_in_exp;
          w_man_nxt = in_man;
          w_rm_nxt  = rm;
          // Special values resolve in the accepting cycle straight from the inputs.
          if (in_nan) begin
            w_o_nxt     = {in_sgn, ENC_INF, SIG_QNAN};
            w_ovf_nxt   = 1'b0;
            w_unf_nxt   = 1'b0;
            w_inx_nxt   = 1'b0;
            w_inv_nxt   = in_snan;
            w_state_nxt = S_DONE;
          end else if (in_inf) begin
            w_o_nxt     = {in_sgn, ENC_INF, 64'd0};
            w_ovf_nxt   = 1'b0;
            w_unf_nxt   = 1'b0;
            w_inx_nxt   = 1'b0;
            w_inv_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else if (in_man == 68'd0) begin
            w_o_nxt     = {in_sgn, 79'd0};
            w_ovf_nxt   = 1'b0;
            w_unf_nxt   = 1'b0;
            w_inx_nxt   = 1'b0;
            w_inv_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else if (w_in_exp < EXP_ONE) begin
            w_state_nxt = S_RSH;
          end else if (!in_man[67] && (w_in_exp > EXP_ONE)) begin
            w_state_nxt = S_LSH;
          end else begin
            w_state_nxt = S_RND;
          end
        end
      end

      S_LSH: begin
        // Byte steps while the top byte is empty and exponent headroom allows.
        if ((r_man[67:60] == 8'd0) && (r_exp > EXP_EIGHT)) begin
          w_man_nxt = {r_man[59:0], 8'd0};
          w_exp_nxt = r_exp - EXP_EIGHT;
        end else begin
          w_man_nxt = {r_man[66:0], 1'b0};
          w_exp_nxt = r_exp - EXP_ONE;
        end
        if (w_man_nxt[67] || (w_exp_nxt == EXP_ONE)) begin
          w_state_nxt = S_RND;
        end
      end

      S_RSH: begin
        // Very small exponents collapse to a pure sticky bit in one step.
        if (r_exp <= EXP_FLUSH) begin
          w_man_nxt = {67'd0, |r_man};
          w_exp_nxt = EXP_ONE;
        end else if (r_exp < EXP_RSH8) begin
          w_man_nxt = {8'd0, r_man[67:9], r_man[8] | (|r_man[7:0])};
          w_exp_nxt = r_exp + EXP_EIGHT;
        end else begin
          w_man_nxt = {1'b0, r_man[67:2], r_man[1] | r_man[0]};
          w_exp_nxt = r_exp + EXP_ONE;
        end
        if (w_exp_nxt == EXP_ONE) begin
          w_state_nxt = S_RND;
        end
      end

      S_RND: begin
        w_o_nxt     = w_rnd_o;
        w_ovf_nxt   = w_rnd_ovf;
        w_unf_nxt   = w_rnd_unf;
        w_inx_nxt   = w_rnd_inx;
        w_inv_nxt   = 1'b0;
        w_state_nxt = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sgn   <= 1'b0;
      r_exp   <= '0;
      r_man   <= '0;
      r_rm    <= '0;
      r_o     <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_inx   <= 1'b0;
      r_inv   <= 1'b0;
    end else if (ce) begin
      r_state <= w_state_nxt;
      r_sgn   <= w_sgn_nxt;
      r_exp   <= w_exp_nxt;
      r_man   <= w_man_nxt;
      r_rm    <= w_rm_nxt;
      r_o     <= w_o_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
      r_inx   <= w_inx_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ce;
  assign out_valid = (r_state == S_DONE);
  assign o         = r_o;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign inexact   = r_inx;
  assign invalid   = r_inv;

endmodule

`default_nettype wire

// File: tb/tb_fp_compose80.sv
// ============================================================================
// Module   : tb_fp_compose80
// Purpose  : Directed self-checking bench for fp_compose80.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_compose80;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic        in_sgn;
  logic [16:0] in_exp;
  logic [67:0] in_man;
  logic        in_inf;
  logic        in_nan;
  logic        in_snan;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] o;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic        invalid;

  int errors = 0;
  int checks = 0;

  fp_compose80 dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sgn    (in_sgn),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .in_inf    (in_inf),
    .in_nan    (in_nan),
    .in_snan   (in_snan),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {overflow, underflow, inexact, invalid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the accepting edge.
  task automatic send(input string tag, input logic s, input logic [16:0] e,
                      input logic [67:0] m, input logic inf, input logic nan,
                      input logic snan, input logic [2:0] mode);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "/ready"}, {79'd0, in_ready}, 80'd1);
    in_sgn   = s;
    in_exp   = e;
    in_man   = m;
    in_inf   = inf;
    in_nan   = nan;
    in_snan  = snan;
    rm       = mode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts the accepting cycle as cycle 1.
  task automatic wait_out(input string tag, input int want_lat);
    int n;
    n = 1;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "/latency"}, 80'(n), 80'(want_lat));
  endtask

  task automatic run(input string tag, input logic s, input logic [16:0] e,
                     input logic [67:0] m, input logic inf, input logic nan,
                     input logic snan, input logic [2:0] mode,
                     input logic [79:0] want_o, input logic [3:0] want_f,
                     input int want_lat);
    send(tag, s, e, m, inf, nan, snan, mode);
    wait_out(tag, want_lat);
    chk({tag, "/o"}, o, want_o);
    chk({tag, "/flags"}, {76'd0, flags_now()}, {76'd0, want_f});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/released"}, {79'd0, out_valid}, 80'd0);
  endtask

  logic [79:0] held_o;
  logic        seen_valid;

  initial begin
    rst       = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    in_sgn    = 1'b0;
    in_exp    = '0;
    in_man    = '0;
    in_inf    = 1'b0;
    in_nan    = 1'b0;
    in_snan   = 1'b0;
    rm        = 3'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("reset/out_valid", {79'd0, out_valid}, 80'd0);
    chk("reset/o", o, 80'd0);
    chk("reset/flags", {76'd0, flags_now()}, 80'd0);
    chk("reset/in_ready", {79'd0, in_ready}, 80'd1);
    ce = 1'b0;
    #1;
    chk("ce_low/in_ready", {79'd0, in_ready}, 80'd0);
    ce = 1'b1;
    #1;

    // Already normalised value, exact
    run("norm_one", 1'b0, 17'd16383, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h3FFF, 64'd0}, 4'b0000, 2);
    // Eight byte-sized left shifts
    run("lsh8", 1'b0, 17'd16447, 68'h0_0000_0000_0000_0008, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h3FFF, 64'd0}, 4'b0000, 10);
    // Left shift stopping at exp 1 (subnormal result)
    run("lsh_to_sub", 1'b0, 17'd3, 68'h0_0000_0000_0000_0008, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h0000, 64'h4}, 4'b0000, 4);
    // exp 0 denormalises by one, exact
    run("rsh1", 1'b0, 17'd0, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h0000, 64'h8000_0000_0000_0000}, 4'b0000, 3);
    // exp -8: one byte step then one bit step
    run("rsh9", 1'b0, 17'h1FFF8, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h0000, 64'h0080_0000_0000_0000}, 4'b0000, 4);
    // Sticky collected from shifted-out bits, rounded up
    run("rsh9_sticky_rup", 1'b0, 17'h1FFF8, 68'h8_0000_0000_0000_0081, 1'b0, 1'b0, 1'b0, 3'd3,
        {1'b0, 15'h0000, 64'h0080_0000_0000_0001}, 4'b0110, 4);
    // exp -100 collapses to sticky only
    run("flush_rne", 1'b0, 17'h1FF9C, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h0000, 64'd0}, 4'b0110, 3);
    run("flush_rup", 1'b0, 17'h1FF9C, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd3,
        {1'b0, 15'h0000, 64'h1}, 4'b0110, 3);

    // lsb 1, guard 1: tie goes up to even under RNE, truncated under RTZ
    run("tie_odd_rne", 1'b0, 17'd16383, 68'h8_0000_0000_0000_000C, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h3FFF, 64'h2}, 4'b0010, 2);
    run("tie_odd_rtz", 1'b0, 17'd16383, 68'h8_0000_0000_0000_000C, 1'b0, 1'b0, 1'b0, 3'd1,
        {1'b0, 15'h3FFF, 64'h1}, 4'b0010, 2);
    // lsb 0, guard 1, round 1: above half
    run("above_half_rne", 1'b0, 17'd16383, 68'h8_0000_0000_0000_0006, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h3FFF, 64'h1}, 4'b0010, 2);
    run("above_half_rtz", 1'b0, 17'd16383, 68'h8_0000_0000_0000_0006, 1'b0, 1'b0, 1'b0, 3'd1,
        {1'b0, 15'h3FFF, 64'h0}, 4'b0010, 2);
    // Exact tie with even lsb: RNE stays, RMM goes away from zero
    run("tie_even_rne", 1'b0, 17'd16383, 68'h8_0000_0000_0000_0004, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h3FFF, 64'h0}, 4'b0010, 2);
    run("tie_even_rmm", 1'b0, 17'd16383, 68'h8_0000_0000_0000_0004, 1'b0, 1'b0, 1'b0, 3'd4,
        {1'b0, 15'h3FFF, 64'h1}, 4'b0010, 2);
    // Directed modes on a negative operand
    run("neg_rdn", 1'b1, 17'd16383, 68'h8_0000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 3'd2,
        {1'b1, 15'h3FFF, 64'h1}, 4'b0010, 2);
    run("neg_rup", 1'b1, 17'd16383, 68'h8_0000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 3'd3,
        {1'b1, 15'h3FFF, 64'h0}, 4'b0010, 2);
    // Unused mode code behaves as RNE
    run("rm7_as_rne", 1'b0, 17'd16383, 68'h8_0000_0000_0000_000C, 1'b0, 1'b0, 1'b0, 3'd7,
        {1'b0, 15'h3FFF, 64'h2}, 4'b0010, 2);
    // Rounding carry-out renormalises and bumps the exponent
    run("carry_out", 1'b0, 17'd16383, 68'hF_FFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h4000, 64'd0}, 4'b0010, 2);
    // Subnormal rounding into the hidden bit encodes exp 1
    run("sub_to_norm", 1'b0, 17'd1, 68'h7_FFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h0001, 64'd0}, 4'b0110, 2);

    // Overflow by mode and sign
    run("ovf_rne", 1'b0, 17'd32767, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h7FFF, 64'd0}, 4'b1010, 2);
    run("ovf_rtz", 1'b0, 17'd32767, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd1,
        {1'b0, 15'h7FFE, 64'hFFFF_FFFF_FFFF_FFFF}, 4'b1010, 2);
    run("ovf_rdn_neg", 1'b1, 17'd32767, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd2,
        {1'b1, 15'h7FFF, 64'd0}, 4'b1010, 2);
    run("ovf_rup_neg", 1'b1, 17'd32767, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd3,
        {1'b1, 15'h7FFE, 64'hFFFF_FFFF_FFFF_FFFF}, 4'b1010, 2);
    run("ovf_big_exp", 1'b0, 17'd65535, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h7FFF, 64'd0}, 4'b1010, 2);

    // Specials
    run("inf_neg", 1'b1, 17'd5, 68'h1, 1'b1, 1'b0, 1'b0, 3'd0,
        {1'b1, 15'h7FFF, 64'd0}, 4'b0000, 1);
    run("qnan_over_inf", 1'b0, 17'd5, 68'h1, 1'b1, 1'b1, 1'b0, 3'd0,
        {1'b0, 15'h7FFF, 64'h8000_0000_0000_0000}, 4'b0000, 1);
    run("zero_neg", 1'b1, 17'd100, 68'h0, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b1, 15'h0000, 64'd0}, 4'b0000, 1);

    // Signalling NaN held stable while the consumer stalls
    send("snan_hold", 1'b0, 17'd0, 68'h0, 1'b0, 1'b1, 1'b1, 3'd0);
    wait_out("snan_hold", 1);
    held_o = o;
    chk("snan_hold/o", held_o, {1'b0, 15'h7FFF, 64'h8000_0000_0000_0000});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("snan_hold/valid", {79'd0, out_valid}, 80'd1);
      chk("snan_hold/stable", o, {1'b0, 15'h7FFF, 64'h8000_0000_0000_0000});
      chk("snan_hold/invalid", {79'd0, invalid}, 80'd1);
    end
    // ce low blocks completion even with out_ready high
    ce        = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ce_low/done_held", {79'd0, out_valid}, 80'd1);
    ce = 1'b1;
    #1;
    chk("no_bypass/in_ready", {79'd0, in_ready}, 80'd0);
    tick();
    out_ready = 1'b0;
    chk("snan_hold/released", {79'd0, out_valid}, 80'd0);
    chk("snan_hold/idle_ready", {79'd0, in_ready}, 80'd1);

    // Reset (with ce low) during a left-shift sequence discards the operation
    send("rst_mid", 1'b0, 17'd16447, 68'h0_0000_0000_0000_0008, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (3) tick();
    rst = 1'b1;
    ce  = 1'b0;
    tick();
    rst = 1'b0;
    ce  = 1'b1;
    out_ready = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen_valid = seen_valid | out_valid;
      tick();
    end
    out_ready = 1'b0;
    chk("rst_mid/no_output", {79'd0, seen_valid}, 80'd0);
    chk("rst_mid/o_cleared", o, 80'd0);
    chk("rst_mid/in_ready", {79'd0, in_ready}, 80'd1);

    // Operation after the aborted one completes normally
    run("after_rst", 1'b0, 17'd16383, 68'h8_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 3'd0,
        {1'b0, 15'h3FFF, 64'd0}, 4'b0000, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
